// File: rtl/branch_resolve_unit_if.sv
// Request/resolution bundle between decode/ALU, the branch resolve unit and fetch.
//   in_*   : branch request (valid/ready) from decode/ALU into the unit
//   out_*  : resolution (valid/ready) from the unit to fetch
//   flush  : squash pulse to fetch, issued when a taken resolution is accepted
//   stat_* : outcome counters, present only when BRU_STATS_EN is defined
// Modports: slave = branch resolve unit side, master = request/fetch side.
interface branch_resolve_unit_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PC_WIDTH = 32
);
  logic                in_valid;
  logic                in_ready;
  logic                in_is_bne;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic [PC_WIDTH-1:0] in_pc;
  logic [15:0]         in_imm;
  logic                out_valid;
  logic                out_ready;
  logic                out_taken;
  logic [PC_WIDTH-1:0] out_next_pc;
  logic                flush;
`ifdef BRU_STATS_EN
  logic [31:0]         stat_taken;
  logic [31:0]         stat_not_taken;
`endif

  modport slave (
    input  in_valid, in_is_bne, in_a, in_b, in_pc, in_imm, out_ready,
    output in_ready, out_valid, out_taken, out_next_pc, flush
`ifdef BRU_STATS_EN
    , output stat_taken, stat_not_taken
`endif
  );

  modport master (
    output in_valid, in_is_bne, in_a, in_b, in_pc, in_imm, out_ready,
    input  in_ready, out_valid, out_taken, out_next_pc, flush
`ifdef BRU_STATS_EN
    , input stat_taken, stat_not_taken
`endif
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: resolves BEQ/BNE requests and hands the next PC to fetch.
// Three-state FSM IDLE -> EVAL -> RESP -> IDLE; one request in flight at a time.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : branch_resolve_unit_if.slave (request in, resolution out, flush)
// flush is the only combinational output: it marks the exact cycle a taken
// resolution is accepted (out_valid & out_ready & out_taken) and is masked by reset.
// Optional feature macro: BRU_STATS_EN adds stat_taken/stat_not_taken counters.
module branch_resolve_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  branch_resolve_unit_if.slave     bus
);

  localparam int unsigned IMM_W  = 16;
  localparam int unsigned SEXT_W = PC_WIDTH - IMM_W - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                is_bne_q, is_bne_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [IMM_W-1:0]    imm_q, imm_d;
  logic                out_valid_q, out_valid_d;
  logic                out_taken_q, out_taken_d;
  logic [PC_WIDTH-1:0] out_next_pc_q, out_next_pc_d;

  logic                eq_c;
  logic                taken_c;
  logic [PC_WIDTH-1:0] seq_pc_c;
  logic [PC_WIDTH-1:0] tgt_pc_c;
  logic                out_hs_c;

  // Compare and next-PC datapath on the captured request (wraps modulo 2^PC_WIDTH).
  assign eq_c     = ((a_q ^ b_q) == '0);
  assign taken_c  = is_bne_q ? ~eq_c : eq_c;
  assign seq_pc_c = pc_q + PC_WIDTH'(4);
  assign tgt_pc_c = seq_pc_c + {{SEXT_W{imm_q[IMM_W-1]}}, imm_q, 2'b00};

  // Resolution accepted by fetch this cycle; reset overrides the handshake.
  assign out_hs_c = out_valid_q & bus.out_ready & ~reset;

  // Next-state and register-input logic.
  always_comb begin
    state_d       = state_q;
    is_bne_d      = is_bne_q;
    a_d           = a_q;
    b_d           = b_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    out_valid_d   = out_valid_q;
    out_taken_d   = out_taken_q;
    out_next_pc_d = out_next_pc_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          is_bne_d = bus.in_is_bne;
          a_d      = bus.in_a;
          b_d      = bus.in_b;
          pc_d     = bus.in_pc;
          imm_d    = bus.in_imm;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        out_taken_d   = taken_c;
        out_next_pc_d = taken_c ? tgt_pc_c : seq_pc_c;
        out_valid_d   = 1'b1;
        state_d       = S_RESP;
      end
      S_RESP: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      is_bne_q      <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      pc_q          <= '0;
      imm_q         <= '0;
      out_valid_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      out_next_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      is_bne_q      <= is_bne_d;
      a_q           <= a_d;
      b_q           <= b_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      out_valid_q   <= out_valid_d;
      out_taken_q   <= out_taken_d;
      out_next_pc_q <= out_next_pc_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_taken   = out_taken_q;
  assign bus.out_next_pc = out_next_pc_q;
  assign bus.flush       = out_hs_c & out_taken_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_taken_q;
  logic [31:0] stat_not_taken_q;

  // Outcome counters, bumped once per accepted resolution; wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else if (out_hs_c) begin
      if (out_taken_q) stat_taken_q     <= stat_taken_q + 32'd1;
      else             stat_not_taken_q <= stat_not_taken_q + 32'd1;
    end
  end

  assign bus.stat_taken     = stat_taken_q;
  assign bus.stat_not_taken = stat_not_taken_q;
`endif

endmodule
